// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter: default widths, FSM
// encodings, requester IDs and the read-return tag carried down the pipe.
package mem_access_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        QUIET = 2'd2
    } arbState_e;

    typedef struct packed {
        logic valid;
        logic owner;
    } rdTag_t;

endpackage

// File: rtl/mem_access_arbiter_rd_return_pipe.sv
// Shift register of {valid,owner} tags that lines each read grant up with the
// memory's read data RD_LATENCY cycles later; empty means no read is in flight.
module mem_access_arbiter_rd_return_pipe
    import mem_access_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pushOwner,
    output rdTag_t tail,
    output logic   empty
);

    rdTag_t [RD_LATENCY-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages[0] <= '{valid: push, owner: pushOwner};
            for (int i = 1; i < RD_LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < RD_LATENCY; i++) begin
            if (stages[i].valid) empty = 1'b0;
        end
    end

    assign tail = stages[RD_LATENCY-1];

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one memory load/store port between the CPU LSU
// and the DMA engine, with lock support, read-return routing and quiesce.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              quiesce_req,
    output logic              quiesce_ack,
    output arbState_e         dbgState
);

    // Handshake: a request transfers in any cycle where reqN_valid && reqN_ready;
    // ready is combinational and never asserted without a matching valid.
    arbState_e state, stateNext;
    logic      rrPtr, locked, lockOwner;
    logic      grantAny, grantId, selWe, selLock, ownerLockIn, pipeEmpty;
    rdTag_t    tail;

    always_comb begin
        grantAny = 1'b0;
        grantId  = rrPtr;
        // Held in reset, the ARB state must not leak grants onto the port.
        if (rst_n && state == ARB && !(quiesce_req && !locked)) begin
            if (locked) begin
                grantId  = lockOwner;
                grantAny = lockOwner ? req1_valid : req0_valid;
            end else if (req0_valid && req1_valid) begin
                grantAny = 1'b1;
            end else if (req0_valid) begin
                grantId  = REQ_CPU;
                grantAny = 1'b1;
            end else if (req1_valid) begin
                grantId  = REQ_DMA;
                grantAny = 1'b1;
            end
        end
    end

    assign selWe       = grantId ? req1_we : req0_we;
    assign selLock     = grantId ? req1_lock : req0_lock;
    assign ownerLockIn = lockOwner ? req1_lock : req0_lock;

    assign req0_ready = grantAny && (grantId == REQ_CPU);
    assign req1_ready = grantAny && (grantId == REQ_DMA);
    assign mem_addr   = grantId ? req1_addr : req0_addr;
    assign mem_wdata  = grantId ? req1_wdata : req0_wdata;
    assign mem_wren   = grantAny && selWe;
    assign mem_rden   = grantAny && !selWe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr     <= 1'b0;
            locked    <= 1'b0;
            lockOwner <= REQ_CPU;
        end else begin
            if (grantAny && selLock) begin
                locked    <= 1'b1;
                lockOwner <= grantId;
            end else if (locked && !ownerLockIn) begin
                locked <= 1'b0;
            end
            if (grantAny && !locked) rrPtr <= ~grantId;
        end
    end

    mem_access_arbiter_rd_return_pipe #(.RD_LATENCY(RD_LATENCY)) uRdPipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (mem_rden),
        .pushOwner(grantId),
        .tail     (tail),
        .empty    (pipeEmpty)
    );

    assign rsp0_valid = tail.valid && (tail.owner == REQ_CPU);
    assign rsp1_valid = tail.valid && (tail.owner == REQ_DMA);
    assign rsp0_data  = mem_rdata;
    assign rsp1_data  = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB;
        else        state <= stateNext;
    end

    // Lock takes precedence over quiesce so atomic sequences are never split.
    always_comb begin
        stateNext = state;
        case (state)
            ARB:     if (quiesce_req && !locked) stateNext = DRAIN;
            DRAIN:   if (pipeEmpty) stateNext = QUIET;
            QUIET:   if (!quiesce_req) stateNext = ARB;
            default: stateNext = ARB;
        endcase
    end

    assign quiesce_ack = (state == QUIET);
    assign dbgState    = state;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed vector table, hand-written lock,
// quiesce and reset sequences, then random traffic against a queue model.
module tb_mem_access_arbiter;
    import mem_access_arbiter_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_we, req0_lock, rsp0_valid;
    logic          req1_valid, req1_ready, req1_we, req1_lock, rsp1_valid;
    logic [AW-1:0] req0_addr, req1_addr, mem_addr;
    logic [DW-1:0] req0_wdata, req1_wdata, rsp0_data, rsp1_data, mem_wdata, mem_rdata;
    logic          mem_wren, mem_rden, quiesce_req, quiesce_ack;
    arbState_e     dbgState;

    int checks = 0;
    int errors = 0;

    mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rden(mem_rden), .mem_rdata(mem_rdata),
        .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v0, we0, v1, we1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] rdata;
        logic [6:0]    expFlags;   // {ready0,ready1,rden,wren,rsp0,rsp1,ack}
        logic [AW-1:0] expAddr;
    } vec_t;

    typedef struct {
        int   due;
        logic owner;
    } pend_t;

    vec_t  tbl[12];
    pend_t pq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkOut(input string tag, input logic [6:0] exp);
        chk(tag, 32'({req0_ready, req1_ready, mem_rden, mem_wren, rsp0_valid, rsp1_valid, quiesce_ack}),
            32'(exp));
    endtask

    task automatic drive(input logic v0, we0, lk0, input logic [AW-1:0] a0,
                         input logic v1, we1, lk1, input logic [AW-1:0] a1,
                         input logic q, input logic [DW-1:0] rd);
        req0_valid = v0; req0_we = we0; req0_lock = lk0; req0_addr = a0;
        req1_valid = v1; req1_we = we1; req1_lock = lk1; req1_addr = a1;
        req0_wdata = {16'hA5A5, a0};
        req1_wdata = {16'h5A5A, a1};
        quiesce_req = q;
        mem_rdata   = rd;
    endtask

    // One bench cycle: drive after the rising edge, then sample on the falling edge.
    task automatic cyc(input logic v0, we0, lk0, input logic [AW-1:0] a0,
                       input logic v1, we1, lk1, input logic [AW-1:0] a1,
                       input logic q, input logic [DW-1:0] rd);
        @(posedge clk); #1;
        drive(v0, we0, lk0, a0, v1, we1, lk1, a1, q, rd);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic v0, we0, input logic [AW-1:0] a0,
                                input logic v1, we1, input logic [AW-1:0] a1,
                                input logic [DW-1:0] rd, input logic [6:0] f,
                                input logic [AW-1:0] ea);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.a0 = a0; v.v1 = v1; v.we1 = we1; v.a1 = a1;
        v.rdata = rd; v.expFlags = f; v.expAddr = ea;
        return v;
    endfunction

    logic rv0, rv1, rwe0, rwe1, rl0, rl1, qz;
    logic mRr, mLocked, mOwner, oldLocked, eg, eid, ewe, elk, es0, es1, pipeEmpty;
    int   mMode;

    initial begin
        // flags: {ready0,ready1,rden,wren,rsp0,rsp1,ack}
        tbl[0]  = mk(1, 0, 16'h0010, 0, 0, 16'h0000, 32'h0,        7'b1010000, 16'h0010);
        tbl[1]  = mk(1, 0, 16'h0020, 1, 0, 16'h0030, 32'h0,        7'b0110000, 16'h0030);
        tbl[2]  = mk(1, 0, 16'h0021, 1, 0, 16'h0031, 32'hDEADBEEF, 7'b1010100, 16'h0021);
        tbl[3]  = mk(1, 0, 16'h0022, 1, 0, 16'h0032, 32'h11111111, 7'b0110010, 16'h0032);
        tbl[4]  = mk(1, 0, 16'h0023, 1, 0, 16'h0033, 32'h22222222, 7'b1010100, 16'h0023);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h33333333, 7'b0000010, 16'h0000);
        tbl[6]  = mk(0, 0, 16'h0000, 1, 1, 16'h0040, 32'h44444444, 7'b0101100, 16'h0040);
        tbl[7]  = mk(1, 1, 16'h0050, 1, 1, 16'h0060, 32'h0,        7'b1001000, 16'h0050);
        tbl[8]  = mk(1, 1, 16'h0051, 1, 0, 16'h0061, 32'h0,        7'b0110000, 16'h0061);
        tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,        7'b0000000, 16'h0000);
        tbl[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h55555555, 7'b0000010, 16'h0000);
        tbl[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,        7'b0000000, 16'h0000);

        // Reset: outputs held low even with both requesters asking.
        rst_n = 1'b0;
        drive(1, 0, 0, 16'h1, 1, 0, 0, 16'h2, 0, 32'h0);
        repeat (2) @(negedge clk);
        chkOut("reset_outputs", 7'b0000000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Solo read, contention, writes and tagged responses.
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].v0, tbl[i].we0, 0, tbl[i].a0, tbl[i].v1, tbl[i].we1, 0, tbl[i].a1, 0, tbl[i].rdata);
            chkOut($sformatf("tbl%0d_flags", i), tbl[i].expFlags);
            if (tbl[i].expFlags[6] || tbl[i].expFlags[5])
                chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].expAddr));
            if (tbl[i].expFlags[3])
                chk($sformatf("tbl%0d_wdata", i), mem_wdata,
                    tbl[i].expFlags[6] ? {16'hA5A5, tbl[i].a0} : {16'h5A5A, tbl[i].a1});
            if (tbl[i].expFlags[2]) chk($sformatf("tbl%0d_rsp0d", i), rsp0_data, tbl[i].rdata);
            if (tbl[i].expFlags[1]) chk($sformatf("tbl%0d_rsp1d", i), rsp1_data, tbl[i].rdata);
        end

        // Lock: DMA holds the port for three writes; CPU waits until the lock drops.
        cyc(1, 1, 0, 16'h0100, 0, 0, 0, 16'h0000, 0, 32'h0);
        chkOut("lk_setup", 7'b1001000);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 16'h0101, 1, 1, 1, 16'h0200, 0, 32'h0);
            chkOut($sformatf("lk_hold%0d", i), 7'b0101000);
        end
        cyc(1, 1, 0, 16'h0101, 0, 1, 0, 16'h0000, 0, 32'h0);
        chkOut("lk_owner_idle", 7'b0000000);
        cyc(1, 1, 0, 16'h0101, 0, 1, 0, 16'h0000, 0, 32'h0);
        chkOut("lk_released", 7'b1001000);

        // Quiesce during lock: owner keeps being served, drain starts after release.
        cyc(1, 1, 0, 16'h0300, 1, 1, 1, 16'h0400, 0, 32'h0);
        chkOut("ql_lock", 7'b0101000);
        cyc(1, 1, 0, 16'h0300, 1, 1, 1, 16'h0401, 1, 32'h0);
        chkOut("ql_held", 7'b0101000);
        cyc(1, 1, 0, 16'h0300, 1, 1, 0, 16'h0402, 1, 32'h0);
        chkOut("ql_unlock", 7'b0101000);
        cyc(1, 1, 0, 16'h0300, 1, 1, 0, 16'h0403, 1, 32'h0);
        chkOut("ql_blocked", 7'b0000000);
        chk("ql_state_arb", 32'(dbgState), 32'(ARB));
        cyc(1, 1, 0, 16'h0300, 1, 1, 0, 16'h0403, 1, 32'h0);
        chkOut("ql_drain", 7'b0000000);
        chk("ql_state_drain", 32'(dbgState), 32'(DRAIN));
        cyc(1, 1, 0, 16'h0300, 1, 1, 0, 16'h0403, 1, 32'h0);
        chkOut("ql_quiet", 7'b0000001);
        cyc(1, 1, 0, 16'h0300, 1, 1, 0, 16'h0403, 0, 32'h0);
        chkOut("ql_drop", 7'b0000001);
        cyc(0, 1, 0, 16'h0300, 1, 1, 0, 16'h0404, 0, 32'h0);
        chkOut("ql_resume", 7'b0101000);

        // Quiesce with a read in flight: ack only after the response is out.
        cyc(1, 0, 0, 16'h0500, 0, 0, 0, 16'h0000, 0, 32'h0);
        chkOut("qr_read", 7'b1010000);
        cyc(1, 0, 0, 16'h0501, 1, 0, 0, 16'h0601, 1, 32'h0);
        chkOut("qr_block", 7'b0000000);
        cyc(1, 0, 0, 16'h0501, 1, 0, 0, 16'h0601, 1, 32'hCAFEF00D);
        chkOut("qr_rsp", 7'b0000100);
        chk("qr_rsp_data", rsp0_data, 32'hCAFEF00D);
        cyc(1, 0, 0, 16'h0501, 1, 0, 0, 16'h0601, 1, 32'h0);
        chkOut("qr_empty", 7'b0000000);
        cyc(1, 0, 0, 16'h0501, 1, 0, 0, 16'h0601, 1, 32'h0);
        chkOut("qr_ack", 7'b0000001);
        cyc(1, 0, 0, 16'h0501, 1, 0, 0, 16'h0601, 0, 32'h0);
        chkOut("qr_drop", 7'b0000001);
        cyc(1, 0, 0, 16'h0501, 1, 0, 0, 16'h0601, 0, 32'h0);
        chkOut("qr_resume", 7'b0110000);
        chk("qr_resume_addr", 32'(mem_addr), 32'h0601);
        cyc(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 32'h0);
        cyc(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 32'h77777777);
        chkOut("qr_late_rsp", 7'b0000010);
        chk("qr_late_data", rsp1_data, 32'h77777777);

        // Reset with a read in flight: response dropped, round-robin back to CPU.
        cyc(1, 0, 0, 16'h0700, 0, 0, 0, 16'h0000, 0, 32'h0);
        chkOut("rs_read", 7'b1010000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1, 0, 0, 16'h0701, 1, 0, 0, 16'h0801, 0, 32'h0);
        @(negedge clk);
        chkOut("rs_in_reset", 7'b0000000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 16'h0702, 1, 0, 0, 16'h0802, 0, 32'h0);
        @(negedge clk);
        chkOut("rs_tie", 7'b1010000);
        cyc(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 32'h0);
        chkOut("rs_no_stale", 7'b0000000);
        cyc(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 32'h0);
        chkOut("rs_new_rsp", 7'b0000100);

        // Random traffic against the queue model, starting from a fresh reset.
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mRr = 1'b0; mLocked = 1'b0; mOwner = 1'b0; mMode = 0; qz = 1'b0;
        pq.delete();
        for (int c = 0; c < 600; c++) begin
            rv0  = ($urandom_range(0, 3) != 0);
            rv1  = ($urandom_range(0, 3) != 0);
            rwe0 = $urandom_range(0, 1) == 1;
            rwe1 = $urandom_range(0, 1) == 1;
            rl0  = ($urandom_range(0, 3) == 0);
            rl1  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) qz = ~qz;
            cyc(rv0, rwe0, rl0, 16'($urandom()), rv1, rwe1, rl1, 16'($urandom()), qz, $urandom());

            eg  = 1'b0;
            eid = mRr;
            if (mMode == 0 && !(qz && !mLocked)) begin
                if (mLocked) begin
                    eid = mOwner;
                    eg  = mOwner ? rv1 : rv0;
                end else if (rv0 || rv1) begin
                    eg  = 1'b1;
                    eid = (rv0 && rv1) ? mRr : rv1;
                end
            end
            ewe = eid ? rwe1 : rwe0;
            elk = eid ? rl1 : rl0;
            es0 = (pq.size() > 0) && pq[0].due == c && pq[0].owner == 1'b0;
            es1 = (pq.size() > 0) && pq[0].due == c && pq[0].owner == 1'b1;

            chkOut($sformatf("rnd%0d_flags", c),
                   {eg && !eid, eg && eid, eg && !ewe, eg && ewe, es0, es1, mMode == 2});
            if (eg) begin
                chk($sformatf("rnd%0d_addr", c), 32'(mem_addr), 32'(eid ? req1_addr : req0_addr));
                if (ewe) chk($sformatf("rnd%0d_wdata", c), mem_wdata, eid ? req1_wdata : req0_wdata);
            end
            if (es0) chk($sformatf("rnd%0d_rsp0d", c), rsp0_data, mem_rdata);
            if (es1) chk($sformatf("rnd%0d_rsp1d", c), rsp1_data, mem_rdata);

            pipeEmpty = (pq.size() == 0);
            if (es0 || es1) void'(pq.pop_front());
            if (eg && !ewe) pq.push_back('{due: c + LAT, owner: eid});
            oldLocked = mLocked;
            if (eg && !oldLocked) mRr = ~eid;
            if (eg && elk) begin
                mLocked = 1'b1;
                mOwner  = eid;
            end else if (mLocked && !(mOwner ? rl1 : rl0)) begin
                mLocked = 1'b0;
            end
            case (mMode)
                0: if (qz && !oldLocked) mMode = 1;
                1: if (pipeEmpty) mMode = 2;
                default: if (!qz) mMode = 0;
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
